// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
// data_mem_arbiter: round-robin two-port sequencer for the single-port data memory.
// Ports: clk, reset_n, a_*/b_* requester ports, mem_* memory side, busy status.
module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

  // Owner encoding: 0 = port A, 1 = port B.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              owner;
  logic              last_owner;
  logic              we_q;
  logic              oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              any_req;
  logic              pick_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              in_idle;
  logic              in_acc;
  logic              in_done;
  logic              resp;

  assign in_idle = (state == IDLE);
  assign in_acc  = (state == ACCESS);
  assign in_done = (state == DONE);

  // Under contention the port that did not own the last
  // completed access wins; a lone request always wins.
  assign any_req = a_req | b_req;
  assign pick_b  = b_req & (~a_req | (last_owner == OWN_A));

  assign sel_we    = pick_b ? b_we    : a_we;
  assign sel_addr  = pick_b ? b_addr  : a_addr;
  assign sel_wdata = pick_b ? b_wdata : a_wdata;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = any_req ? ACCESS : IDLE;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request latch: taken only on the IDLE->ACCESS step so the
  // memory address and data hold their last values otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= OWN_A;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (in_idle && any_req) begin
      owner   <= pick_b ? OWN_B : OWN_A;
      we_q    <= sel_we;
      oor_q   <= (sel_addr >= LIMIT);
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Read data is sampled at the end of ACCESS; writes and
  // out-of-range accesses return zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (in_acc) begin
      rdata_q <= (we_q | oor_q) ? '0 : mem_rdata;
    end
  end

  // Round-robin history only advances on a completed ACCESS,
  // so an access aborted by reset leaves it untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWN_B;
    end else if (in_acc) begin
      last_owner <= owner;
    end
  end

  // Reads and errors respond in DONE; in-range writes
  // complete with the grant alone.
  assign resp = in_done & (~we_q | oor_q);

  assign a_gnt    = in_acc & (owner == OWN_A);
  assign b_gnt    = in_acc & (owner == OWN_B);

  assign a_rvalid = resp & (owner == OWN_A);
  assign b_rvalid = resp & (owner == OWN_B);

  assign a_err    = a_rvalid & oor_q;
  assign b_err    = b_rvalid & oor_q;

  assign a_rdata  = a_rvalid ? rdata_q : '0;
  assign b_rdata  = b_rvalid ? rdata_q : '0;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rw    = in_acc & we_q & ~oor_q;

  assign busy = ~in_idle;

endmodule

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
// tb_data_mem_arbiter: directed and random checks of the
// two-port memory arbiter against a transaction-level model.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        a_req, a_we, a_gnt, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rw, busy;

  int checks;
  int errors;

  // Physical memory seen by the DUT (wraps modulo 128).
  logic [31:0] mem [0:127];
  // Model's view of what memory must contain.
  logic [31:0] ref_mem [0:127];
  // Model round-robin history: 0 = A, 1 = B.
  logic        last_own;

  data_mem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .b_err     (b_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[6:0]];

  always @(posedge clk)
    if (mem_rw) mem[mem_addr[6:0]] <= mem_wdata;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic p, input logic we,
                         input logic [31:0] addr,
                         input logic [31:0] wd);
    if (p) begin
      b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_gnt"}, a_gnt, 0);
    chk({tag, "_b_gnt"}, b_gnt, 0);
    chk({tag, "_a_rv"}, a_rvalid, 0);
    chk({tag, "_b_rv"}, b_rvalid, 0);
    chk({tag, "_a_err"}, a_err, 0);
    chk({tag, "_b_err"}, b_err, 0);
    chk({tag, "_a_rd"}, a_rdata, 0);
    chk({tag, "_b_rd"}, b_rdata, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwd"}, mem_wdata, 0);
    chk({tag, "_mrw"}, mem_rw, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One 3-cycle access. Called in an IDLE cycle with port p's
  // request already presented; returns one cycle into the next IDLE.
  task automatic run_slot(input logic p, input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic keep,
                          input logic inj,
                          input logic [31:0] inj_addr);
    logic        oor;
    logic        rsp;
    logic [31:0] exp_rd;
    oor = (addr >= 32'd128);
    rsp = !we || oor;
    exp_rd = oor ? 32'd0 : ref_mem[addr[6:0]];
    @(posedge clk); #1;
    chk("acc_gnt", p ? b_gnt : a_gnt, 1);
    chk("acc_gnt_other", p ? a_gnt : b_gnt, 0);
    chk("acc_busy", busy, 1);
    chk("acc_mem_rw", mem_rw, {31'd0, we && !oor});
    chk("acc_mem_addr", mem_addr, addr);
    chk("acc_mem_wdata", mem_wdata, wd);
    chk("acc_rv", a_rvalid | b_rvalid, 0);
    if (we && !oor) ref_mem[addr[6:0]] = wd;
    last_own = p;
    if (!keep) begin
      if (p) b_req = 1'b0; else a_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("done_rv", p ? b_rvalid : a_rvalid, {31'd0, rsp});
    chk("done_rv_other", p ? a_rvalid : b_rvalid, 0);
    chk("done_err", p ? b_err : a_err, {31'd0, rsp && oor});
    chk("done_err_other", p ? a_err : b_err, 0);
    if (rsp) chk("done_rdata", p ? b_rdata : a_rdata, exp_rd);
    chk("done_rdata_other", p ? a_rdata : b_rdata, 0);
    chk("done_mem_rw", mem_rw, 0);
    chk("done_gnt", a_gnt | b_gnt, 0);
    chk("done_busy", busy, 1);
    if (inj) set_req(!p, 1'b0, inj_addr, 32'd0);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_mem_rw", mem_rw, 0);
    chk("idle_gnt", a_gnt | b_gnt, 0);
    chk("idle_rv", a_rvalid | b_rvalid, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    last_own = 1'b1;
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 4) == 0)
      return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(128, 400))
                                         : $urandom | 32'h8000_0000;
    return 32'($urandom_range(0, 127));
  endfunction

  initial begin
    logic        w;
    logic        we0, we1;
    logic [31:0] ad0, ad1, wd0, wd1;
    int          nbad;
    checks = 0;
    errors = 0;
    a_we = 0; a_addr = 0; a_wdata = 0;
    b_we = 0; b_addr = 0; b_wdata = 0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = $urandom;
      mem[i] = ref_mem[i];
    end
    ref_mem[5] = 32'hDEADBEEF;
    mem[5] = 32'hDEADBEEF;

    do_reset();

    // A read of a known word.
    set_req(1'b0, 1'b0, 32'd5, 32'd0);
    run_slot(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0);

    // B write then A read-back.
    set_req(1'b1, 1'b1, 32'd10, 32'h12345678);
    run_slot(1'b1, 1'b1, 32'd10, 32'h12345678, 1'b0, 1'b0, 32'd0);
    set_req(1'b0, 1'b0, 32'd10, 32'd0);
    run_slot(1'b0, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("t2_readback", ref_mem[10], 32'h12345678);

    // Out-of-range write must never reach memory.
    set_req(1'b0, 1'b1, 32'd200, 32'hBADC0DE0);
    run_slot(1'b0, 1'b1, 32'd200, 32'hBADC0DE0, 1'b0, 1'b0, 32'd0);
    chk("t4_mem72", mem[72], ref_mem[72]);

    // Continuous contention after reset: A, B, A, B.
    @(negedge clk);
    do_reset();
    set_req(1'b0, 1'b0, 32'd7, 32'd0);
    set_req(1'b1, 1'b0, 32'd9, 32'd0);
    for (int k = 0; k < 4; k++) begin
      w = ~last_own;
      chk("t3_order", {31'd0, w}, {31'd0, k[0]});
      run_slot(w, 1'b0, w ? 32'd9 : 32'd7, 32'd0, 1'b1, 1'b0, 32'd0);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk); #1;
    chk("t3_quiet", busy, 0);

    // B request raised during DONE of an A access.
    set_req(1'b0, 1'b0, 32'd20, 32'd0);
    run_slot(1'b0, 1'b0, 32'd20, 32'd0, 1'b0, 1'b1, 32'd21);
    run_slot(1'b1, 1'b0, 32'd21, 32'd0, 1'b0, 1'b0, 32'd0);

    // Reset in the middle of a write by A after A owned last.
    set_req(1'b0, 1'b0, 32'd2, 32'd0);
    run_slot(1'b0, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 32'd0);
    set_req(1'b0, 1'b1, 32'd3, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("t5_acc_rw", mem_rw, 1);
    chk("t5_acc_gnt", a_gnt, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rw_async", mem_rw, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_gnt_async", a_gnt, 0);
    chk("t5_maddr_async", mem_addr, 0);
    a_req = 1'b0;
    last_own = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_rv", a_rvalid | b_rvalid, 0);
    chk("t5_mem3", mem[3], ref_mem[3]);
    set_req(1'b0, 1'b0, 32'd3, 32'd0);
    set_req(1'b1, 1'b0, 32'd4, 32'd0);
    chk("t5_winner", {31'd0, ~last_own}, 0);
    run_slot(1'b0, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0);
    run_slot(1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0);

    // Random traffic with gaps and contention.
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("gap_busy", busy, 0);
        chk("gap_rw", mem_rw, 0);
      end
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      ad0 = rnd_addr();
      ad1 = rnd_addr();
      wd0 = $urandom;
      wd1 = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        set_req(1'b0, we0, ad0, wd0);
        set_req(1'b1, we1, ad1, wd1);
        w = ~last_own;
        if (w) begin
          run_slot(1'b1, we1, ad1, wd1, 1'b0, 1'b0, 32'd0);
          run_slot(1'b0, we0, ad0, wd0, 1'b0, 1'b0, 32'd0);
        end else begin
          run_slot(1'b0, we0, ad0, wd0, 1'b0, 1'b0, 32'd0);
          run_slot(1'b1, we1, ad1, wd1, 1'b0, 1'b0, 32'd0);
        end
      end else begin
        w = 1'($urandom_range(0, 1));
        set_req(w, we0, ad0, wd0);
        run_slot(w, we0, ad0, wd0, 1'b0, 1'b0, 32'd0);
      end
    end

    nbad = 0;
    for (int i = 0; i < 128; i++)
      if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_image", 32'(nbad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
